uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, one byte in flight.
// Optional launch timeout: define UART_ARB_TIMEOUT_EN to abort when uart_tx_busy never rises.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BUSY_TIMEOUT = 16,
    localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_done,
    input  logic                            uart_tx_busy,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    output logic [ID_W-1:0]                 active_id,
    output logic                            tx_error
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (BUSY_TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: BUSY_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         active_q, active_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;

    logic [PAYLOAD_BITS-1:0] req_bytes [NUM_REQ];
    logic [ID_W-1:0]         win;
    logic                    win_found;
    logic [ID_W-1:0]         cand;
    int unsigned             idx;
    logic [ID_W-1:0]         ptr_next;
    logic                    timeout;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // First valid requester in circular order starting at ptr_q.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    assign ptr_next = (active_q == ID_W'(NUM_REQ - 1)) ? '0 : active_q + ID_W'(1);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles spent in WAIT_BUSY without seeing busy; cleared while launching.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLaunch) begin
            cnt_d = '0;
        end else if (state_q == StWaitBusy && !uart_tx_busy && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == StWaitBusy) && !uart_tx_busy &&
                     (cnt_q == CNT_W'(BUSY_TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        data_d     = data_q;
        req_ready  = '0;
        req_done   = '0;
        uart_tx_en = 1'b0;
        tx_error   = 1'b0;

        case (state_q)
            StIdle: begin
                // uart_tx may still be shifting an aborted byte after reset.
                if (!uart_tx_busy && win_found) begin
                    req_ready[win] = 1'b1;
                    data_d         = req_bytes[win];
                    active_d       = win;
                    state_d        = StLaunch;
                end
            end
            StLaunch: begin
                uart_tx_en = 1'b1;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                if (uart_tx_busy) begin
                    state_d = StWaitDone;
                end else if (timeout) begin
                    tx_error = 1'b1;
                    ptr_d    = ptr_next;
                    state_d  = StIdle;
                end
            end
            StWaitDone: begin
                if (!uart_tx_busy) begin
                    req_done[active_q] = 1'b1;
                    ptr_d              = ptr_next;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            req_ready  = '0;
            req_done   = '0;
            uart_tx_en = 1'b0;
            tx_error   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            active_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            data_q   <= data_d;
        end
    end

    assign uart_tx_data = data_q;
    assign active_id    = active_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_done_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(req_done));
    a_pulses_excl:  assert property (@(posedge clk) disable iff (rst)
                        $onehot0({|req_ready, |req_done, uart_tx_en, tx_error}));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int PB           = 8;
    localparam int BUSY_TIMEOUT = 16;
    localparam int BUSY_LEN     = 20;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic        uart_tx_busy = 1'b0;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic [1:0]  active_id;
    logic        tx_error;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .PAYLOAD_BITS(PB),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .active_id   (active_id),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget at %0t", name, $time);
    endtask

    // uart_tx stand-in: busy rises the cycle after en and stays high BUSY_LEN cycles.
    bit busy_auto  = 1'b1;
    bit busy_force = 1'b0;
    bit en_seen    = 1'b0;
    int busy_cnt   = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (en_seen && busy_auto) busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        uart_tx_busy = busy_force || (busy_cnt != 0);
    end

    // Reference model: pointer, the byte/owner on the line and where that byte is in its life.
    int m_ptr = 0, m_active = 0, m_data = 0, m_wb = 0;
    bit m_free = 1'b1, m_launch = 1'b0, m_flight = 1'b0, m_seen = 1'b0;
    int n_ptr, n_active, n_data, n_wb;
    bit n_free, n_launch, n_flight, n_seen;
    logic [3:0] e_ready, e_done;
    logic e_en, e_err;
    int w;
    int done_count = 0;
    int launched_id[$];
    int launched_data[$];

    function automatic int first_valid(input logic [3:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[2'((p + k) % NUM_REQ)]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    initial forever begin
        @(negedge clk);
        en_seen = uart_tx_en;
        e_ready = '0;
        e_done  = '0;
        e_en    = 1'b0;
        e_err   = 1'b0;
        n_ptr = m_ptr; n_active = m_active; n_data = m_data; n_wb = m_wb;
        n_free = m_free; n_launch = m_launch; n_flight = m_flight; n_seen = m_seen;
        if (rst) begin
            n_ptr = 0; n_active = 0; n_data = 0; n_wb = 0;
            n_free = 1'b1; n_launch = 1'b0; n_flight = 1'b0; n_seen = 1'b0;
        end else if (m_free) begin
            if (!uart_tx_busy && (|req_valid)) begin
                w = first_valid(req_valid, m_ptr);
                e_ready[2'(w)] = 1'b1;
                n_free   = 1'b0;
                n_launch = 1'b1;
                n_active = w;
                n_data   = int'((req_data >> (w * PB)) & 32'hFF);
            end
        end else if (m_launch) begin
            e_en     = 1'b1;
            n_launch = 1'b0;
            n_flight = 1'b1;
            n_seen   = 1'b0;
            n_wb     = 0;
        end else if (m_flight) begin
            if (!m_seen) begin
                n_wb = m_wb + 1;
                if (uart_tx_busy) begin
                    n_seen = 1'b1;
                end else if (TIMEOUT_ON && n_wb == BUSY_TIMEOUT + 1) begin
                    e_err    = 1'b1;
                    n_flight = 1'b0;
                    n_free   = 1'b1;
                    n_ptr    = (m_active + 1) % NUM_REQ;
                end
            end else if (!uart_tx_busy) begin
                e_done[2'(m_active)] = 1'b1;
                n_flight = 1'b0;
                n_free   = 1'b1;
                n_ptr    = (m_active + 1) % NUM_REQ;
            end
        end
        check("model req_ready", 32'(req_ready), 32'(e_ready));
        check("model req_done", 32'(req_done), 32'(e_done));
        check("model uart_tx_en", 32'(uart_tx_en), 32'(e_en));
        check("model tx_error", 32'(tx_error), 32'(e_err));
        check("model uart_tx_data", 32'(uart_tx_data), m_data);
        check("model active_id", 32'(active_id), m_active);
        if (uart_tx_en) begin
            launched_id.push_back(int'(active_id));
            launched_data.push_back(int'(uart_tx_data));
        end
        if (req_done != '0) done_count++;
        m_ptr = n_ptr; m_active = n_active; m_data = n_data; m_wb = n_wb;
        m_free = n_free; m_launch = n_launch; m_flight = n_flight; m_seen = n_seen;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, output logic [3:0] seen);
        seen = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = req_ready;
                return;
            end
        end
        expire(name);
    endtask

    task automatic wait_done(input string name, output logic [3:0] seen);
        seen = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req_done != '0) begin
                seen = req_done;
                return;
            end
        end
        expire(name);
    endtask

    task automatic wait_launches(input string name, input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (launched_id.size() >= n) return;
        end
        expire(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0] seen;
    time t_en, t_evt;
    int dc;
    int exp_id[5]   = '{0, 1, 2, 3, 0};
    int exp_data[5] = '{'h10, 'h11, 'h12, 'h13, 'h10};

    initial begin
        // Reset values once released with nothing pending.
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset uart_tx_en", 32'(uart_tx_en), 32'h0);
        check("reset uart_tx_data", 32'(uart_tx_data), 32'h0);
        check("reset active_id", 32'(active_id), 32'h0);
        check("reset req_done", 32'(req_done), 32'h0);

        // Single request from requester 2.
        tick();
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        wait_ready("single ready", seen);
        check("single ready", 32'(seen), 32'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        t_en = $time;
        check("single en", 32'(uart_tx_en), 32'h1);
        check("single data", 32'(uart_tx_data), 32'hA5);
        check("single active_id", 32'(active_id), 32'h2);
        wait_done("single done", seen);
        t_evt = $time;
        check("single done", 32'(seen), 32'h4);
        check("single en-to-done cycles", 32'((t_evt - t_en) / 10), 32'd21);

        // Fairness from a fresh pointer with every requester pending.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        launched_id.delete();
        launched_data.delete();
        wait_launches("fairness launches", 5);
        tick();
        req_valid = '0;
        if (launched_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("fairness id", 32'(launched_id[i]), 32'(exp_id[i]));
                check("fairness data", 32'(launched_data[i]), 32'(exp_data[i]));
            end
        end
        wait_done("fairness last done", seen);
        check("fairness last done", 32'(seen), 32'h1);

        // Rotation: after requester 1, requester 3 beats requester 0.
        tick();
        req_valid = 4'b0010;
        wait_ready("rotation serve 1", seen);
        check("rotation serve 1", 32'(seen), 32'h2);
        tick();
        req_valid = '0;
        wait_done("rotation done 1", seen);
        tick();
        launched_id.delete();
        req_valid = 4'b1001;
        wait_ready("rotation first", seen);
        check("rotation first", 32'(seen), 32'h8);
        tick();
        req_valid = 4'b0001;
        wait_done("rotation done 3", seen);
        check("rotation done 3", 32'(seen), 32'h8);
        wait_ready("rotation second", seen);
        check("rotation second", 32'(seen), 32'h1);
        tick();
        req_valid = '0;
        wait_done("rotation done 0", seen);
        check("rotation launch count", 32'(launched_id.size()), 32'd2);
        if (launched_id.size() == 2) begin
            check("rotation order[0]", 32'(launched_id[0]), 32'd3);
            check("rotation order[1]", 32'(launched_id[1]), 32'd0);
        end

        // Busy gating: no grant while busy, grant in the cycle busy falls.
        tick();
        busy_force = 1'b1;
        req_valid  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy gated ready", 32'(req_ready), 32'h0);
        end
        tick();
        busy_force = 1'b0;
        @(negedge clk);
        check("busy release grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_done("busy gating done", seen);
        check("busy gating done", 32'(seen), 32'h2);

        // Reset during WAIT_DONE while uart_tx is still busy.
        tick();
        req_valid = 4'b1111;
        wait_ready("midreset grant", seen);
        check("midreset grant", 32'(seen), 32'h4);
        repeat (4) @(negedge clk);
        tick();
        dc  = done_count;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset data", 32'(uart_tx_data), 32'h0);
        check("midreset active_id", 32'(active_id), 32'h0);
        check("midreset ready", 32'(req_ready), 32'h0);
        check("midreset en", 32'(uart_tx_en), 32'h0);
        wait_ready("midreset regrant", seen);
        #1;
        check("midreset regrant", 32'(seen), 32'h1);
        check("midreset no done", 32'(done_count), 32'(dc));
        tick();
        req_valid = '0;
        wait_done("midreset done", seen);
        check("midreset done", 32'(seen), 32'h1);

`ifdef UART_ARB_TIMEOUT_EN
        // Launch timeout: busy never rises.
        tick();
        busy_auto = 1'b0;
        req_valid = 4'b0100;
        wait_ready("timeout grant", seen);
        check("timeout grant", 32'(seen), 32'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        t_en = $time;
        dc   = done_count;
        begin : wait_err
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (tx_error) disable wait_err;
            end
            expire("timeout error");
        end
        t_evt = $time;
        check("timeout en-to-error cycles", 32'((t_evt - t_en) / 10), 32'd17);
        #1;
        check("timeout no done", 32'(done_count), 32'(dc));
        tick();
        busy_auto = 1'b1;
        req_valid = 4'b1001;
        wait_ready("timeout next", seen);
        check("timeout next", 32'(seen), 32'h8);
        tick();
        req_valid = '0;
        wait_done("timeout next done", seen);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
